// File: rtl/memory_stage.sv
// Memory stage: issues data-memory loads/stores, stalls the front end until they
// complete, and times out hung transactions. Optional MEM_ALIGN_CHECK_EN traps misaligned accesses.
module memory_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [71:0] ex_to_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] bp_mem,
  output logic [37:0] mem_to_wb,
  output logic        bus_err
);

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  rd;
    logic        mem_read;
  } ex_to_mem_s;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_to_wb_s;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;

  ex_to_mem_s       ex;
  state_e           state_p0;
  logic [CNT_W-1:0] wait_cnt_p0;
  mem_to_wb_s       wb_p1;
  logic             bus_err_p1;

  logic mem_op;
  logic misaligned;
  logic timeout;
  logic done;

  assign ex = ex_to_mem;

`ifdef MEM_ALIGN_CHECK_EN
  // Only checked at issue; an accepted request keeps its (aligned) address.
  assign misaligned = (state_p0 == IDLE) && (ex.mem_read || ex.mem_write) &&
                      (ex.alu_result[1:0] != 2'b00);
  assign dmem_addr  = ex.alu_result;
`else
  assign misaligned = 1'b0;
  assign dmem_addr  = {ex.alu_result[31:2], 2'b00};
`endif

  assign mem_op  = (ex.mem_read || ex.mem_write) && !misaligned;
  // The final counted cycle times out and wins over a coincident gnt/rvalid.
  assign timeout = (state_p0 != IDLE) && (wait_cnt_p0 == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    done = 1'b0;
    case (state_p0)
      IDLE, REQ: done = ex.mem_write && dmem_gnt;
      RESP:      done = dmem_rvalid;
      default:   done = 1'b0;
    endcase
  end

  assign stall      = mem_op && !done && !timeout;
  assign dmem_req   = ((state_p0 == IDLE) && mem_op) || (state_p0 == REQ);
  assign dmem_we    = ex.mem_write;
  assign dmem_wdata = ex.write_data;
  assign bp_mem     = ex.alu_result;

  // ---- stage p0 -> p1: transaction control and write-back register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0    <= IDLE;
      wait_cnt_p0 <= '0;
      wb_p1       <= '0;
      bus_err_p1  <= 1'b0;
    end else begin
      bus_err_p1      <= timeout || misaligned;
      wb_p1.rd        <= ex.rd;
      wb_p1.result    <= (state_p0 == RESP && dmem_rvalid) ? dmem_rdata : ex.alu_result;
      wb_p1.reg_write <= ex.reg_write && !ex.mem_write && !stall && !timeout && !misaligned;
      case (state_p0)
        IDLE: begin
          wait_cnt_p0 <= '0;
          if (mem_op) begin
            if (dmem_gnt) state_p0 <= ex.mem_write ? IDLE : RESP;
            else          state_p0 <= REQ;
          end
        end
        REQ: begin
          if (timeout) begin
            state_p0    <= IDLE;
            wait_cnt_p0 <= '0;
          end else begin
            wait_cnt_p0 <= wait_cnt_p0 + CNT_W'(1);
            if (dmem_gnt) state_p0 <= ex.mem_write ? IDLE : RESP;
          end
        end
        RESP: begin
          if (timeout || dmem_rvalid) begin
            state_p0    <= IDLE;
            wait_cnt_p0 <= '0;
          end else begin
            wait_cnt_p0 <= wait_cnt_p0 + CNT_W'(1);
          end
        end
        default: begin
          state_p0    <= IDLE;
          wait_cnt_p0 <= '0;
        end
      endcase
    end
  end

  assign mem_to_wb = wb_p1;
  assign bus_err   = bus_err_p1;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage; each transaction's outcome is predicted
// from its grant/response timing relative to the MAX_WAIT budget.
module tb_memory_stage;

  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] ex_to_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] bp_mem;
  logic [37:0] mem_to_wb;
  logic        bus_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  memory_stage #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_to_mem(ex_to_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall(stall), .bp_mem(bp_mem), .mem_to_wb(mem_to_wb), .bus_err(bus_err)
  );

  wire [31:0] wb_res = mem_to_wb[37:6];
  wire [4:0]  wb_rd  = mem_to_wb[5:1];
  wire        wb_rw  = mem_to_wb[0];

  function automatic logic [71:0] mk_ex(logic [31:0] alu, logic [31:0] wd, logic mw,
                                        logic rw, logic [4:0] rd, logic mr);
    return {alu, wd, mw, rw, rd, mr};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    ex_to_mem = '0;
    #3;
    n_checks++; if (mem_to_wb !== 38'd0) $display("FAIL reset_wb got=%h exp=0", mem_to_wb); else n_pass++;
    n_checks++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err got=%b exp=0", bus_err); else n_pass++;
    n_checks++; if (dmem_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL reset_idle_nop req=%b stall=%b exp=0/0", dmem_req, stall); else n_pass++;
    ex_to_mem = mk_ex(32'h400, 0, 0, 1, 5'd3, 1);
    #1;
    n_checks++; if (dmem_req !== 1'b1 || stall !== 1'b1)
      $display("FAIL reset_idle_load req=%b stall=%b exp=1/1", dmem_req, stall); else n_pass++;
    ex_to_mem = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_nop(logic [31:0] alu, logic [4:0] rd, logic rw);
    @(negedge clk);
    ex_to_mem = mk_ex(alu, $urandom, 0, rw, rd, 0);
    dmem_gnt = 0; dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    #1;
    n_checks++; if (stall !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL nop_ctrl stall=%b req=%b exp=0/0", stall, dmem_req); else n_pass++;
    n_checks++; if (bp_mem !== alu) $display("FAIL nop_bp got=%h exp=%h", bp_mem, alu); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (mem_to_wb !== {alu, rd, rw} || bus_err !== 1'b0)
      $display("FAIL nop_wb got=%h err=%b exp=%h err=0", mem_to_wb, bus_err, {alu, rd, rw}); else n_pass++;
  endtask

  // g: cycles from issue to gnt (0 = same cycle); r: cycles from gnt to rvalid.
  task automatic run_mem(bit is_load, logic [31:0] addr, logic [31:0] wdata, logic [31:0] data,
                         logic [4:0] rd, int g, int r, bit spur);
    int c, e;
    bit tmo;
    c   = is_load ? g + r : g;
    tmo = (c >= MW);
    e   = tmo ? MW : c;
    for (int k = 0; k <= e; k++) begin
      @(negedge clk);
      ex_to_mem   = mk_ex(addr, wdata, !is_load, is_load, rd, is_load);
      dmem_gnt    = (k == g);
      dmem_rvalid = (is_load && k == g + r) || (spur && k <= g && $urandom_range(0, 1) == 1);
      dmem_rdata  = (k == g + r) ? data : $urandom;
      #1;
      n_checks++; if (stall !== (k < e)) $display("FAIL mem_stall k=%0d got=%b exp=%b", k, stall, k < e); else n_pass++;
      n_checks++; if (dmem_req !== (k <= g)) $display("FAIL mem_req k=%0d got=%b exp=%b", k, dmem_req, k <= g); else n_pass++;
      if (k == 0) begin
        n_checks++; if (dmem_we !== !is_load || dmem_addr !== (addr & 32'hFFFF_FFFC) || dmem_wdata !== wdata)
          $display("FAIL mem_bus we=%b addr=%h wd=%h exp=%b/%h/%h", dmem_we, dmem_addr, dmem_wdata,
                   !is_load, addr & 32'hFFFF_FFFC, wdata); else n_pass++;
      end
      @(posedge clk); #1;
      if (k < e) begin
        n_checks++; if (wb_rw !== 1'b0 || bus_err !== 1'b0)
          $display("FAIL mem_bubble k=%0d rw=%b err=%b exp=0/0", k, wb_rw, bus_err); else n_pass++;
      end else if (tmo) begin
        n_checks++; if (bus_err !== 1'b1 || wb_rw !== 1'b0)
          $display("FAIL mem_timeout err=%b rw=%b exp=1/0", bus_err, wb_rw); else n_pass++;
      end else begin
        n_checks++; if (bus_err !== 1'b0 || wb_rw !== is_load)
          $display("FAIL mem_done err=%b rw=%b exp=0/%b", bus_err, wb_rw, is_load); else n_pass++;
        if (is_load) begin
          n_checks++; if (wb_res !== data || wb_rd !== rd)
            $display("FAIL load_data got=%h rd=%0d exp=%h rd=%0d", wb_res, wb_rd, data, rd); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_directed();
    run_nop(32'h10, 5'd5, 1'b1);
    run_mem(0, 32'h100, 32'hCAFE_0001, 0, 5'd0, 0, 1, 0);
    run_nop(32'h11, 5'd6, 1'b1);
    run_mem(1, 32'h200, 0, 32'hDEAD_BEEF, 5'd7, 2, 1, 0);
    run_mem(1, 32'h300, 0, 32'h1234_5678, 5'd8, 1000, 1, 0);
    run_nop(32'h12, 5'd9, 1'b1);
  endtask

  task automatic test_timeout_boundary();
    run_mem(1, 32'h40, 0, 32'hA5A5_0001, 5'd10, MW - 3, 2, 1);
    run_mem(1, 32'h44, 0, 32'hA5A5_0002, 5'd11, MW - 2, 2, 0);
    run_mem(0, 32'h48, 32'h77, 0, 5'd0, MW, 1, 0);
    run_nop(32'h13, 5'd12, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit ld;
      ld = 1'($urandom_range(0, 1));
      run_mem(ld, $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 5'($urandom_range(1, 31)),
              $urandom_range(0, 5), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) run_nop($urandom, 5'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_unaligned();
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    ex_to_mem = mk_ex(32'h203, 0, 0, 1, 5'd4, 1);
    dmem_gnt = 0; dmem_rvalid = 0;
    #1;
    n_checks++; if (dmem_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL misalign_ctrl req=%b stall=%b exp=0/0", dmem_req, stall); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus_err !== 1'b1 || wb_rw !== 1'b0)
      $display("FAIL misalign_err err=%b rw=%b exp=1/0", bus_err, wb_rw); else n_pass++;
    run_nop(32'h14, 5'd13, 1'b1);
`else
    run_mem(1, 32'h203, 0, 32'h0BAD_F00D, 5'd4, 0, 1, 0);
    run_nop(32'h14, 5'd13, 1'b1);
`endif
  endtask

  task automatic test_reset_mid();
    run_nop(32'h5555_AAAA, 5'd21, 1'b1);
    @(negedge clk);
    ex_to_mem = mk_ex(32'h600, 0, 0, 1, 5'd22, 1);
    dmem_gnt = 1; dmem_rvalid = 0;
    @(negedge clk);
    dmem_gnt = 0;
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL resp_stall got=%b exp=1", stall); else n_pass++;
    rst_n = 1'b0;
    ex_to_mem = '0;
    #1;
    n_checks++; if (mem_to_wb !== 38'd0 || bus_err !== 1'b0)
      $display("FAIL midreset_clear wb=%h err=%b exp=0/0", mem_to_wb, bus_err); else n_pass++;
    n_checks++; if (stall !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL midreset_ctrl stall=%b req=%b exp=0/0", stall, dmem_req); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1; dmem_rdata = 32'hFEED_FACE;
    @(posedge clk); #1;
    n_checks++; if (mem_to_wb !== 38'd0 || bus_err !== 1'b0)
      $display("FAIL late_rvalid wb=%h err=%b exp=0/0", mem_to_wb, bus_err); else n_pass++;
    @(negedge clk);
    dmem_rvalid = 0;
    #1;
    n_checks++; if (dmem_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL post_reset_idle req=%b stall=%b exp=0/0", dmem_req, stall); else n_pass++;
    run_mem(1, 32'h700, 0, 32'h0F0F_0F0F, 5'd23, 0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout_boundary();
    test_unaligned();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter: MAX_WAIT, default 15, cycles a data-memory transaction may stay outstanding before it is declared a bus error.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: ex_to_mem  in  ex_to_mem_s  execute-stage register (alu_result, write_data, mem_write, reg_write, rd, mem_read); upstream holds it stable while stall=1.
REQ-005 Port: dmem_req  out  1  data-memory request valid.
REQ-006 Port: dmem_we  out  1  request is a store.
REQ-007 Port: dmem_addr  out  32  word address.
REQ-008 Port: dmem_wdata  out  32  store data.
REQ-009 Port: dmem_gnt  in  1  request accepted this cycle.
REQ-010 Port: dmem_rvalid  in  1  load data valid; never earlier than the cycle after gnt.
REQ-011 Port: dmem_rdata  in  32  load data.
REQ-012 Port: stall  out  1  freezes fetch/decode/execute registers.
REQ-013 Port: bp_mem  out  32  forwarding value to execute; equals ex_to_mem.alu_result, combinational.
REQ-014 Port: mem_to_wb  out  mem_to_wb_s  registered {result[31:0], rd[4:0], reg_write}.
REQ-015 Port: bus_err  out  1  one-cycle pulse on transaction timeout.

Function
REQ-016 The FSM SHALL have states IDLE, REQ (request outstanding, awaiting gnt) and RESP (load granted, awaiting rvalid).
REQ-017 The block SHALL assert dmem_req while (IDLE and ex_to_mem.mem_read or mem_write) or in REQ; dmem_we=mem_write, dmem_addr=alu_result, dmem_wdata=write_data.
REQ-018 IDLE/REQ with gnt: a store SHALL complete that cycle and return to/stay in IDLE; a load SHALL go to RESP; without gnt, the FSM SHALL go to or stay in REQ.
REQ-019 RESP with rvalid SHALL capture dmem_rdata into mem_to_wb.result at that edge and return to IDLE.
REQ-020 stall SHALL equal 1 whenever a memory op is present and not completing this cycle; a store granted in IDLE SHALL cause no stall.
REQ-021 A non-memory op SHALL pass to mem_to_wb with result=alu_result in exactly 1 cycle.
REQ-022 While stall=1, mem_to_wb.reg_write SHALL be registered as 0 (bubble).
REQ-023 A 4-bit-or-wider wait counter SHALL clear on entry to REQ from IDLE, increment each cycle in REQ/RESP, and, on reaching MAX_WAIT, force IDLE, pulse bus_err, deassert stall and register reg_write=0.
REQ-024 Counter wrap SHALL be impossible; timeout takes priority over a simultaneous gnt/rvalid.
REQ-025 rvalid received in IDLE or REQ SHALL be ignored.

Reset
REQ-026 With rst_n=0, the block SHALL asynchronously force IDLE, counter=0, mem_to_wb all-zero, and bus_err=0; dmem_req and stall SHALL then follow REQ-017/REQ-020 combinationally.
REQ-027 Reset mid-transaction SHALL abandon it; the late rvalid SHALL be dropped per REQ-025.

Configuration
REQ-028 With MEM_ALIGN_CHECK_EN defined, a memory op with alu_result[1:0]!=0 SHALL not issue dmem_req, SHALL not stall, SHALL register reg_write=0, and SHALL raise bus_err for one cycle.
REQ-029 Without MEM_ALIGN_CHECK_EN, dmem_addr[1:0] SHALL be forced to 0 and the access SHALL proceed normally.

Verification
REQ-030 ADD with alu_result=0x10, rd=5 -> next cycle mem_to_wb={0x10,5,1}, stall never 1.
REQ-031 Store to 0x100, gnt same cycle -> dmem_req=1 and dmem_we=1 for one cycle, stall=0, no reg_write.
REQ-032 Load from 0x200, gnt after 2 cycles, rvalid 1 cycle later with 0xDEADBEEF -> stall=1 for 3 cycles, then mem_to_wb.result=0xDEADBEEF.
REQ-033 Load with gnt never asserted, MAX_WAIT=15 -> bus_err pulses on the 15th wait cycle, FSM in IDLE, stall drops.
REQ-034 Reset asserted while in RESP, rvalid pulsed after release -> state IDLE, mem_to_wb unchanged at zero.
REQ-035 Load from 0x203, with MEM_ALIGN_CHECK_EN -> no dmem_req, bus_err=1 one cycle; without it -> dmem_addr=0x200.
